// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and the instruction encoder's error/state types.
// Opcode values match the decoder so the two stay in lockstep.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        ILLEGAL = 2'd1,
        RANGE   = 2'd2,
        ALIGN   = 2'd3
    } enc_err_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } enc_state_e;

    // True when v is the sign extension of its low 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = $signed(v) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle handshake from the program source and the instruction-memory
// write port; master drives the request, slave returns ready.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready
    );
endinterface

interface imem_wr_if #(parameter int unsigned ADDR_W = 10);
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (output wr_en, wr_addr, wr_data, input wr_ready);
    modport slave  (input wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I packer: lays decoded fields out per instruction format
// and flags illegal opcodes, out-of-range immediates and odd B/J offsets.
module instr_pack
    import riscv_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output enc_err_e    err_code
);

    always_comb begin
        word     = '0;
        err_code = NONE;
        case (opcode)
            OPC_OP: begin
                word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                // Only OP-IMM funct3 001/101 are shifts; they carry funct7 and a 5-bit shamt.
                if (opcode == OPC_OP_IMM && funct3[1:0] == 2'b01) begin
                    word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    if (imm[31:5] != '0) err_code = RANGE;
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, opcode};
                    if (!fits_signed(imm, 12)) err_code = RANGE;
                end
            end
            OPC_STORE: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                if (!fits_signed(imm, 12)) err_code = RANGE;
            end
            OPC_BRANCH: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                if (!fits_signed(imm, 13)) err_code = RANGE;
                else if (imm[0])           err_code = ALIGN;
            end
            OPC_LUI, OPC_AUIPC: begin
                word = {imm[31:12], rd, opcode};
                if (imm[11:0] != '0) err_code = RANGE;
            end
            OPC_JAL: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                if (!fits_signed(imm, 21)) err_code = RANGE;
                else if (imm[0])           err_code = ALIGN;
            end
            default: begin
                err_code = ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded field bundles, packs them into RV32I
// words and streams legal words into instruction memory at ascending addresses.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    instr_encoder_if.slave    in_bus,
    imem_wr_if.master         wr_bus,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              busy
);

    enc_state_e  state;
    enc_err_e    err_q;
    enc_err_e    pack_err;
    logic [31:0] word;
    logic        accept;
    logic        last;

    instr_pack u_pack (
        .opcode   (in_bus.in_opcode),
        .funct3   (in_bus.in_funct3),
        .funct7   (in_bus.in_funct7),
        .rd       (in_bus.in_rd),
        .rs1      (in_bus.in_rs1),
        .rs2      (in_bus.in_rs2),
        .imm      (in_bus.in_imm),
        .word     (word),
        .err_code (pack_err)
    );

    // Single output register: a new bundle may enter whenever the held word leaves this cycle.
    assign in_bus.in_ready = (state == RUN) && !start && (!wr_bus.wr_en || wr_bus.wr_ready);
    assign accept          = in_bus.in_valid && in_bus.in_ready;
    assign last            = (count[ADDR_W-1:0] == '1);
    assign busy            = (state != IDLE);
    assign err_code        = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            count          <= '0;
            err            <= 1'b0;
            err_q          <= NONE;
            wr_bus.wr_en   <= 1'b0;
            wr_bus.wr_addr <= '0;
            wr_bus.wr_data <= '0;
        end else if (start) begin
            state        <= RUN;
            count        <= '0;
            err          <= 1'b0;
            err_q        <= NONE;
            wr_bus.wr_en <= 1'b0;
        end else begin
            if (wr_bus.wr_en && wr_bus.wr_ready) wr_bus.wr_en <= 1'b0;
            if (accept) begin
                if (pack_err == NONE) begin
                    wr_bus.wr_en   <= 1'b1;
                    wr_bus.wr_data <= word;
                    wr_bus.wr_addr <= count[ADDR_W-1:0];
                    count          <= count + (ADDR_W+1)'(1);
                    if (last) state <= FULL;
                end else begin
                    err <= 1'b1;
                    if (!err) err_q <= pack_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed program-load scenarios followed by
// random field bundles, checked against an arithmetic reference of the RV32I formats.
module tb_instr_encoder;

    localparam int unsigned AW = 3;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } bundle_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   count;
    logic          err;
    logic [1:0]    err_code;
    logic          busy;

    instr_encoder_if        in_if ();
    imem_wr_if #(.ADDR_W(AW)) wr_if ();

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_bus   (in_if),
        .wr_bus   (wr_if),
        .count    (count),
        .err      (err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int  checks   = 0;
    int  failures = 0;
    wr_t q[$];

    // Behavioural model: 0 idle, 1 loading, 2 memory full.
    int  m_state   = 0;
    int  m_count   = 0;
    int  m_err     = 0;
    int  m_code    = 0;
    bit  m_pending = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bundle_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [31:0] imm);
        bundle_t b;
        b.op = op; b.f3 = f3; b.f7 = f7; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
        return b;
    endfunction

    // Reference encoding: field placement by shift/mask, legality by signed integer ranges.
    function automatic void ref_enc(input bundle_t b, output logic [31:0] w, output int code);
        logic [31:0] i, base, rdf, f3f, rs1f, rs2f, f7f;
        int signed   v;
        i    = b.imm;
        v    = $signed(b.imm);
        base = 32'(b.op);
        rdf  = 32'(b.rd)  << 7;
        f3f  = 32'(b.f3)  << 12;
        rs1f = 32'(b.rs1) << 15;
        rs2f = 32'(b.rs2) << 20;
        f7f  = 32'(b.f7)  << 25;
        code = 0;
        w    = '0;
        case (b.op)
            7'h33: w = f7f | rs2f | rs1f | f3f | rdf | base;
            7'h13, 7'h03, 7'h67: begin
                if (b.op == 7'h13 && (b.f3 == 3'd1 || b.f3 == 3'd5)) begin
                    if (i > 32'd31) code = 2;
                    w = f7f | ((i & 32'h1F) << 20) | rs1f | f3f | rdf | base;
                end else begin
                    if (v < -2048 || v > 2047) code = 2;
                    w = ((i & 32'hFFF) << 20) | rs1f | f3f | rdf | base;
                end
            end
            7'h23: begin
                if (v < -2048 || v > 2047) code = 2;
                w = (((i >> 5) & 32'h7F) << 25) | rs2f | rs1f | f3f | ((i & 32'h1F) << 7) | base;
            end
            7'h63: begin
                if (v < -4096 || v > 4095) code = 2;
                else if (i[0])             code = 3;
                w = (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3F) << 25) | rs2f | rs1f | f3f
                  | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 32'h1) << 7) | base;
            end
            7'h37, 7'h17: begin
                if ((i & 32'hFFF) != 0) code = 2;
                w = (i & 32'hFFFFF000) | rdf | base;
            end
            7'h6F: begin
                if (v < -1048576 || v > 1048575) code = 2;
                else if (i[0])                   code = 3;
                w = (((i >> 20) & 32'h1) << 31) | (((i >> 1) & 32'h3FF) << 21)
                  | (((i >> 11) & 32'h1) << 20) | (((i >> 12) & 32'hFF) << 12) | rdf | base;
            end
            default: code = 1;
        endcase
    endfunction

    task automatic step(input logic s, input logic v, input bundle_t b, input logic wrr);
        logic        exp_rdy, acc;
        logic [31:0] w;
        int          code;
        wr_t         e;
        @(negedge clk);
        start            = s;
        in_if.in_valid   = v;
        in_if.in_opcode  = b.op;
        in_if.in_funct3  = b.f3;
        in_if.in_funct7  = b.f7;
        in_if.in_rd      = b.rd;
        in_if.in_rs1     = b.rs1;
        in_if.in_rs2     = b.rs2;
        in_if.in_imm     = b.imm;
        wr_if.wr_ready   = wrr;
        #1;
        exp_rdy = (m_state == 1) && !s && (!m_pending || wrr);
        chk("in_ready", 32'(in_if.in_ready), 32'(exp_rdy));
        acc  = v && exp_rdy;
        code = 0;
        w    = '0;
        if (acc) ref_enc(b, w, code);
        @(posedge clk);
        if (s) begin
            if (m_pending && !wrr && q.size() > 0) void'(q.pop_back());
            m_state = 1; m_count = 0; m_err = 0; m_code = 0; m_pending = 1'b0;
        end else begin
            if (m_pending && wrr) m_pending = 1'b0;
            if (acc) begin
                if (code == 0) begin
                    e.addr = AW'(m_count);
                    e.data = w;
                    q.push_back(e);
                    m_pending = 1'b1;
                    m_count++;
                    if (m_count == (1 << AW)) m_state = 2;
                end else begin
                    if (m_err == 0) m_code = code;
                    m_err = 1;
                end
            end
        end
        #1;
        chk("count",    32'(count),        32'(m_count));
        chk("err",      32'(err),          32'(m_err));
        chk("err_code", 32'(err_code),     32'(m_code));
        chk("busy",     32'(busy),         32'(m_state != 0));
        chk("wr_en",    32'(wr_if.wr_en),  32'(m_pending));
    endtask

    // Monitor: pops the scoreboard on every completed write, checks hold stability under backpressure.
    initial begin
        logic          hold;
        logic [AW-1:0] ha;
        logic [31:0]   hd;
        wr_t           e;
        hold = 1'b0;
        ha   = '0;
        hd   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold && wr_if.wr_en) begin
                    chk("hold_addr", 32'(wr_if.wr_addr), 32'(ha));
                    chk("hold_data", wr_if.wr_data, hd);
                end
                if (wr_if.wr_en && wr_if.wr_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty scoreboard at %0t",
                                 wr_if.wr_addr, wr_if.wr_data, $time);
                    end else begin
                        e = q.pop_front();
                        chk("wr_addr", 32'(wr_if.wr_addr), 32'(e.addr));
                        chk("wr_data", wr_if.wr_data, e.data);
                    end
                end
                hold = wr_if.wr_en && !wr_if.wr_ready;
                ha   = wr_if.wr_addr;
                hd   = wr_if.wr_data;
            end
        end
    end

    function automatic bundle_t rand_bundle();
        logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        int         bnd [14] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                                  1048574, 1048576, -1048576, -1048578, 31, 32};
        bundle_t b;
        b.op  = ($urandom_range(0, 11) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
        b.f3  = 3'($urandom);
        b.f7  = 7'($urandom);
        b.rd  = 5'($urandom);
        b.rs1 = 5'($urandom);
        b.rs2 = 5'($urandom);
        case ($urandom_range(0, 5))
            0:       b.imm = 32'($urandom_range(0, 80)) - 32'd40;
            1:       b.imm = 32'(bnd[$urandom_range(0, 13)]);
            2:       b.imm = $urandom;
            3:       b.imm = $urandom & 32'hFFFFF000;
            4:       b.imm = 32'($urandom_range(0, 31));
            default: b.imm = (32'($urandom_range(0, 400)) - 32'd200) << 1;
        endcase
        return b;
    endfunction

    initial begin
        bundle_t nop, addi5, sub3, beq8, addi2048, jal3;
        nop      = mk(7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0);
        addi5    = mk(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        sub3     = mk(7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
        beq8     = mk(7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8);
        addi2048 = mk(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
        jal3     = mk(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3);

        rst = 1'b1; start = 1'b0;
        in_if.in_valid = 1'b0; in_if.in_opcode = '0; in_if.in_funct3 = '0; in_if.in_funct7 = '0;
        in_if.in_rd = '0; in_if.in_rs1 = '0; in_if.in_rs2 = '0; in_if.in_imm = '0;
        wr_if.wr_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wr_en",    32'(wr_if.wr_en),    32'd0);
        chk("rst_wr_addr",  32'(wr_if.wr_addr),  32'd0);
        chk("rst_wr_data",  wr_if.wr_data,       32'd0);
        chk("rst_count",    32'(count),          32'd0);
        chk("rst_err",      32'(err),            32'd0);
        chk("rst_err_code", 32'(err_code),       32'd0);
        chk("rst_busy",     32'(busy),           32'd0);
        chk("rst_in_ready", 32'(in_if.in_ready), 32'd0);
        rst = 1'b0;

        // Idle ignores bundles until start.
        step(0, 1, addi5, 1);
        step(1, 1, addi5, 1);
        step(0, 1, addi5, 1);
        chk("addi_word", wr_if.wr_data, 32'h00500093);
        chk("addi_addr", 32'(wr_if.wr_addr), 32'd0);
        step(0, 1, sub3, 1);
        chk("sub_word", wr_if.wr_data, 32'h402081B3);
        chk("sub_addr", 32'(wr_if.wr_addr), 32'd1);
        step(0, 1, beq8, 1);
        chk("beq_word", wr_if.wr_data, 32'h00208463);
        chk("beq_addr", 32'(wr_if.wr_addr), 32'd2);
        step(0, 0, nop, 1);

        // Sticky first error, cleared by start.
        step(0, 1, addi2048, 1);
        step(0, 1, jal3, 1);
        step(0, 0, nop, 1);
        step(1, 0, nop, 1);

        // Backpressure: word held for three cycles, then drains without loss.
        step(0, 1, addi5, 1);
        step(0, 1, sub3, 0);
        step(0, 1, sub3, 0);
        step(0, 1, sub3, 0);
        step(0, 1, sub3, 1);
        step(0, 1, beq8, 1);
        step(0, 0, nop, 1);

        // Fill to capacity, check blocking, restart at address 0.
        step(1, 0, nop, 1);
        for (int unsigned k = 0; k < (1 << AW); k++) step(0, 1, addi5, 1);
        step(0, 1, sub3, 1);
        step(0, 1, sub3, 0);
        step(1, 0, nop, 1);
        step(0, 1, sub3, 1);
        chk("restart_addr", 32'(wr_if.wr_addr), 32'd0);
        step(0, 0, nop, 1);

        // Asynchronous reset while a write is stalled.
        step(0, 1, beq8, 1);
        @(negedge clk);
        wr_if.wr_ready = 1'b0;
        in_if.in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_wr_en",    32'(wr_if.wr_en),    32'd0);
        chk("arst_wr_addr",  32'(wr_if.wr_addr),  32'd0);
        chk("arst_wr_data",  wr_if.wr_data,       32'd0);
        chk("arst_count",    32'(count),          32'd0);
        chk("arst_busy",     32'(busy),           32'd0);
        chk("arst_in_ready", 32'(in_if.in_ready), 32'd0);
        m_state = 0; m_count = 0; m_err = 0; m_code = 0; m_pending = 1'b0;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(0, 1, addi5, 1);

        // Randomized traffic.
        step(1, 0, nop, 1);
        for (int unsigned n = 0; n < 800; n++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), rand_bundle(),
                 ($urandom_range(0, 2) != 0));
        end

        repeat (3) step(0, 0, nop, 1);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Inverse of the instruction decoder: accepts decoded instruction fields over a valid/ready handshake, packs them into a 32-bit RV32I instruction word, checks immediate range and alignment, and writes each legal word to instruction memory at a self-incrementing word address. It sits between the test/boot program source and the instruction-memory write port, and is used to load programs without a precompiled hex file.

## Interface
- `ADDR_W`, 10: instruction-memory word-address width; capacity is 2**ADDR_W words.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse: restart loading at address 0 and clear errors.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  encoder can accept the bundle this cycle.
- `in_opcode`  in  7  RV32I major opcode.
- `in_funct3`  in  3  funct3; ignored for LUI/AUIPC/JAL.
- `in_funct7`  in  7  funct7; used for OP, and for OP-IMM shifts (funct3 001/101).
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register numbers; unused fields ignored per format.
- `in_imm`  in  32  immediate as a signed byte offset or value, same convention as the decoder's `imm` output.
- `wr_en`  out  1  write request to instruction memory.
- `wr_ready`  in  1  memory accepts the write this cycle.
- `wr_addr`  out  ADDR_W  word address.
- `wr_data`  out  32  encoded instruction.
- `count`  out  ADDR_W+1  number of words accepted since the last `start`.
- `err`  out  1  sticky error flag.
- `err_code`  out  2  first error: 0 none, 1 illegal opcode, 2 immediate out of range, 3 misaligned B/J offset.
- `busy`  out  1  state is RUN or FULL.

## Operation
- FSM: IDLE, RUN, FULL. Reset enters IDLE. `start` from any state enters RUN. RUN enters FULL on the accept that makes `count` = 2**ADDR_W.
- In IDLE, FULL, and any cycle with `start` high, `in_ready` is 0.
- In RUN, `in_ready` = !wr_en || wr_ready, which gives one output register with pass-through backpressure.
- Accept is `in_valid && in_ready`. The bundle is encoded combinationally and registered into `wr_data`/`wr_addr`.
- Formats:
  - R for OP.
  - I for OP-IMM, LOAD and JALR. OP-IMM shifts take bits [31:25] from `in_funct7` and shamt from `in_imm[4:0]`.
  - S for STORE, B for BRANCH, U for LUI/AUIPC (bits [31:12] from `in_imm[31:12]`), J for JAL.
- Legality checks:
  - I/S: `in_imm` must sign-extend from 12 bits.
  - Shifts: `in_imm[31:5]` must be 0.
  - B: must sign-extend from 13 bits, and bit 0 = 0.
  - J: must sign-extend from 21 bits, and bit 0 = 0.
  - U: `in_imm[11:0]` must be 0, otherwise range error.
  - Any other opcode is illegal.
- When a bundle is illegal, it is still consumed: `wr_en` is not raised, the address does not advance, and `count` does not increment.
  - `err` is set; `err_code` latches only the first error.
  - Both are cleared only by `start` or `rst`.
- Address pointer: reset/start value 0, increments by 1 per legal accept, and never wraps (FULL blocks the input).
- `start` while a word is pending discards it: `wr_en` drops the next cycle.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `count`=0, `err`=0, `err_code`=0, `busy`=0, `in_ready`=0.
- Latency: a legal accept at edge N raises `wr_en` from N+1 until the edge on which `wr_ready` is 1.
- `wr_addr`/`wr_data` are stable while `wr_en`=1 and `wr_ready`=0.
- Throughput is one word per cycle with `wr_ready` held at 1.
- `count` and the FULL transition update on the accept edge, not on the write edge.
- Asynchronous `rst` mid-transfer clears all state immediately. A pending write is dropped.

## Structure
- `riscv_pkg` holds:
  - the opcode constants shared with the decoder;
  - an `enc_err_e` enum (NONE, ILLEGAL, RANGE, ALIGN);
  - an `enc_state_e` enum (IDLE, RUN, FULL).
- Sub-module `instr_pack` is purely combinational: fields in, `word` + `err_code` out.
- Top level holds the FSM, the pointer/count, and the output register.

## Test plan
- start; addi x1,x0,5 (opcode 0010011, f3 0, rd 1, imm 5) -> `wr_data`=0x00500093, `wr_addr`=0, `wr_en` the next cycle, `count`=1.
- sub x3,x1,x2 (funct7 0100000) then beq x1,x2,+8 back-to-back with `wr_ready`=1 -> 0x402081B3 @1, then 0x00208463 @2, one per cycle.
- addi imm=2048 -> no `wr_en`, `err`=1, `err_code`=2. A following jal imm=3 leaves `err_code` at 2. start -> `err`=0.
- Hold `wr_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0, `wr_data`/`wr_addr` stable, no accepts; release -> transfer resumes with no loss or duplication.
- With ADDR_W=2: 4 legal accepts -> FULL, `in_ready`=0, `count`=4; start -> RUN, next word written at address 0.
- Assert `rst` while `wr_en`=1 and `wr_ready`=0 -> all outputs return to reset values in the same cycle; FSM is in IDLE.
